bu_diag_pipe: RTL

BU_DIAG_PIPE -- requirements
Module: bu_diag_pipe

---
 rtl/bu_diag_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bu_diag_pipe.sv
// bu_diag_pipe: (a - b)^2 single-precision pipeline with tag/index tracking and sticky flags.
// Denormal operands and results are flushed to zero; rounding is nearest-even.
module bu_diag_dly #(parameter int W = 1, parameter int N = 1) (
    input  logic         clock,
    input  logic         aclr,
    input  logic         clk_en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s [N];
    always_ff @(posedge clock)
        if (aclr) begin
            for (int i = 0; i < N; i++) s[i] <= '0;
        end else if (clk_en) begin
            s[0] <= d;
            for (int i = 1; i < N; i++) s[i] <= s[i-1];
        end
    assign q = s[N-1];
endmodule

module fpsub #(parameter int LAT = 7) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);
    logic [31:0] x, y, r;
    logic [7:0] d;
    logic [26:0] mx, sh, n;
    logic [53:0] al;
    logic [27:0] s;
    logic [4:0] lz;
    logic [24:0] m;
    logic signed [9:0] e;
    logic up, ov, un, swp;
    always_comb begin
        swp = dataa[30:0] < datab[30:0];
        x = swp ? {~datab[31], datab[30:0]} : dataa;
        y = swp ? dataa : {~datab[31], datab[30:0]};
        d = x[30:23] - y[30:23];
        mx = {|x[30:23], x[22:0], 3'b0};
        al = {|y[30:23], y[22:0], 30'b0} >> d;
        sh = (d < 8'd27) ? {al[53:28], al[27] | (|al[26:0])} : {26'b0, |y[30:23]};
        s = (x[31] ^ y[31]) ? {1'b0, mx} - {1'b0, sh} : {1'b0, mx} + {1'b0, sh};
        lz = '0;
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        n = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << lz;
        up = n[2] & (n[3] | n[1] | n[0]);
        m = {1'b0, n[26:3]} + 25'(up);
        e = 10'(x[30:23]) + 10'(s[27]) + 10'(m[24]) - 10'(lz);
        ov = 1'b0;
        un = 1'b0;
        if (x[30:23] == 8'hFF)
            r = (|x[22:0] || (x[30:0] == y[30:0] && x[31] != y[31])) ? 32'h7FC0_0000 : {x[31], 8'hFF, 23'b0};
        else if (s == '0 || x[30:23] == 8'h00)
            r = '0;
        else if (e >= 10'sd255) begin
            r = {x[31], 8'hFF, 23'b0};
            ov = 1'b1;
        end else if (e <= 10'sd0) begin
            r = {x[31], 31'b0};
            un = 1'b1;
        end else
            r = {x[31], e[7:0], m[22:0]};
    end
    bu_diag_dly #(.W(34), .N(LAT)) u_dly (
        .clock(clock), .aclr(aclr), .clk_en(clk_en),
        .d({ov, un, r}), .q({overflow, underflow, result})
    );
endmodule

module fpsquare #(parameter int LAT = 16) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] data,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        underflow
);
    logic [23:0] f;
    logic [47:0] p;
    logic [24:0] t, m;
    logic signed [10:0] e;
    logic [31:0] r;
    logic up, ov, un, z;
    always_comb begin
        f = {|data[30:23], data[22:0]};
        p = f * f;
        t = p[47] ? p[47:23] : p[46:22];
        up = t[0] & (t[1] | (p[47] ? |p[22:0] : |p[21:0]));
        m = {1'b0, t[24:1]} + 25'(up);
        e = 11'({data[30:23], 1'b0}) - 11'd127 + 11'(p[47]) + 11'(m[24]);
        ov = 1'b0;
        un = 1'b0;
        if (data[30:23] == 8'hFF)
            r = (|data[22:0]) ? 32'h7FC0_0000 : 32'h7F80_0000;
        else if (data[30:23] == 8'h00)
            r = '0;
        else if (e >= 11'sd255) begin
            r = 32'h7F80_0000;
            ov = 1'b1;
        end else if (e <= 11'sd0) begin
            r = '0;
            un = 1'b1;
        end else
            r = {1'b0, e[7:0], m[22:0]};
        z = r[30:0] == '0;
    end
    bu_diag_dly #(.W(35), .N(LAT)) u_dly (
        .clock(clock), .aclr(aclr), .clk_en(clk_en),
        .d({z, ov, un, r}), .q({zero, overflow, underflow, result})
    );
endmodule

module bu_diag_pipe #(
    parameter int SUB_LAT = 7,
    parameter int SQR_LAT = 16,
    parameter int VEC_LEN = 4,
    parameter int TAG_W = 4,
    localparam int IW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1,
    localparam int FW = $clog2(SUB_LAT + SQR_LAT + 1)
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [31:0]      data_a,
    input  logic [31:0]      data_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             clear_status,
    output logic [31:0]      result,
    output logic             out_valid,
    output logic             out_last,
    output logic             zero,
    output logic             overflow,
    output logic             underflow,
    output logic [TAG_W-1:0] out_tag,
    output logic [IW-1:0]    out_index,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic [FW-1:0]    inflight,
    output logic             busy
);
    localparam int L = SUB_LAT + SQR_LAT;
    localparam logic [IW-1:0] LAST = IW'(VEC_LEN - 1);
    logic acc, done, sub_ovf, sub_unf, d_ovf, d_unf, sq_zero, sq_ovf, sq_unf;
    logic [31:0] diff, sq;
    logic [IW-1:0] idx;
    assign acc = in_valid & clk_en;
    fpsub #(.LAT(SUB_LAT)) u_sub (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .dataa(data_a), .datab(data_b),
        .result(diff), .overflow(sub_ovf), .underflow(sub_unf)
    );
    fpsquare #(.LAT(SQR_LAT)) u_sqr (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .data(diff),
        .result(sq), .zero(sq_zero), .overflow(sq_ovf), .underflow(sq_unf)
    );
    // subtractor flags must wait out the squarer latency to line up with its result
    bu_diag_dly #(.W(2), .N(SQR_LAT)) u_flg (
        .clock(clock), .aclr(aclr), .clk_en(clk_en),
        .d({sub_ovf, sub_unf}), .q({d_ovf, d_unf})
    );
    bu_diag_dly #(.W(1 + TAG_W + IW), .N(L)) u_ctl (
        .clock(clock), .aclr(aclr), .clk_en(clk_en),
        .d({acc, in_tag, idx}), .q({out_valid, out_tag, out_index})
    );
    assign out_last = out_valid & (out_index == LAST);
    assign result = out_valid ? sq : 32'd0;
    assign zero = out_valid & sq_zero;
    assign overflow = out_valid & (d_ovf | sq_ovf);
    assign underflow = out_valid & (d_unf | sq_unf);
    // a held output is retired only on the enabled edge that moves it on
    assign done = out_valid & clk_en;
    assign busy = inflight != '0;
    always_ff @(posedge clock)
        if (aclr) begin
            idx <= '0;
            inflight <= '0;
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (acc) idx <= (idx == LAST) ? '0 : idx + 1'b1;
            inflight <= inflight + FW'(acc) - FW'(done);
            sticky_ovf <= (done & overflow) | (sticky_ovf & ~clear_status);
            sticky_unf <= (done & underflow) | (sticky_unf & ~clear_status);
        end
endmodule
